instr_sequencer: RTL and testbench

- Central control sequencer for the single-bus CPU.
- Replaces the OR-of-done fetch restart and the PC==7 halt flag with an explicit fetch -> dispatch -> execute loop.
- Issues one-cycle start pulses to the fetch FSM and to exactly one execute FSM (move, movi, ALU, ALUI, load, store), then waits for that FSM's done.
- Publishes the current bus owner, and detects illegal opcodes, stray done pulses and hung FSMs.

---
 rtl/instr_sequencer.sv | 159 +++++++++++++++
 tb/tb_instr_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Central control sequencer: explicit fetch -> dispatch -> execute loop with
// one-hot start pulses, bus-owner publication and illegal/stray/timeout detection.
module instr_sequencer #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [ADDR_W-1:0] halt_addr,
  input  logic [ADDR_W-1:0] pc_value,
  input  logic              fetch_done,
  input  logic [3:0]        opcode,
  input  logic [5:0]        exec_done,
  output logic              start_fetch,
  output logic [5:0]        start_exec,
  output logic [2:0]        owner,
  output logic              busy,
  output logic              halted,
  output logic              error,
  output logic [1:0]        err_code
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLIMIT = TW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_FETCH_START = 3'd1;
  localparam logic [2:0] S_FETCH_WAIT  = 3'd2;
  localparam logic [2:0] S_DISPATCH    = 3'd3;
  localparam logic [2:0] S_EXEC_WAIT   = 3'd4;
  localparam logic [2:0] S_HALT        = 3'd5;
  localparam logic [2:0] S_ERROR       = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    op_q, op_d;
  logic [2:0]    sel_q, sel_d;
  logic [1:0]    err_q, err_d;

  logic          dec_legal;
  logic [2:0]    dec_sel;
  logic [5:0]    dec_oh;
  logic [5:0]    sel_oh;
  logic [TW-1:0] timer_inc;
  logic          at_halt;

  always_comb begin
    dec_legal = 1'b1;
    dec_sel   = 3'd0;
    case (op_q)
      4'h0:                         dec_sel = 3'd0;
      4'h1:                         dec_sel = 3'd1;
      4'h2, 4'h3, 4'h4, 4'h5:       dec_sel = 3'd2;
      4'h6, 4'h7, 4'h8, 4'h9:       dec_sel = 3'd3;
      4'hA:                         dec_sel = 3'd4;
      4'hB:                         dec_sel = 3'd5;
      default:                      dec_legal = 1'b0;
    endcase
  end

  assign dec_oh    = 6'b000001 << dec_sel;
  assign sel_oh    = 6'b000001 << sel_q;
  assign timer_inc = (timer_q == TLIMIT) ? timer_q : timer_q + 1'b1;
  assign at_halt   = (pc_value == halt_addr);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    op_d    = op_q;
    sel_d   = sel_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = at_halt ? S_HALT : S_FETCH_START;
      end
      S_FETCH_START: begin
        timer_d = '0;
        state_d = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        // a done arriving on the last permitted cycle still wins over timeout
        if (fetch_done) begin
          op_d    = opcode;
          state_d = S_DISPATCH;
        end else begin
          timer_d = timer_inc;
          if (timer_inc == TLIMIT) begin
            state_d = S_ERROR;
            err_d   = 2'd3;
          end
        end
      end
      S_DISPATCH: begin
        timer_d = '0;
        if (!dec_legal) begin
          state_d = S_ERROR;
          err_d   = 2'd1;
        end else begin
          sel_d   = dec_sel;
          state_d = S_EXEC_WAIT;
        end
      end
      S_EXEC_WAIT: begin
        if ((exec_done & ~sel_oh) != 6'b0) begin
          state_d = S_ERROR;
          err_d   = 2'd2;
        end else if ((exec_done & sel_oh) != 6'b0) begin
          if (!run)        state_d = S_IDLE;
          else if (at_halt) state_d = S_HALT;
          else             state_d = S_FETCH_START;
        end else begin
          timer_d = timer_inc;
          if (timer_inc == TLIMIT) begin
            state_d = S_ERROR;
            err_d   = 2'd3;
          end
        end
      end
      S_HALT: begin
        if (!run) state_d = S_IDLE;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      op_q    <= '0;
      sel_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      op_q    <= op_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    start_fetch = (state_q == S_FETCH_START);
    start_exec  = (state_q == S_DISPATCH && dec_legal) ? dec_oh : '0;
    case (state_q)
      S_FETCH_START, S_FETCH_WAIT: owner = 3'd1;
      S_DISPATCH:                  owner = 3'd2 + dec_sel;
      S_EXEC_WAIT:                 owner = 3'd2 + sel_q;
      default:                     owner = 3'd0;
    endcase
    busy     = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_ERROR);
    halted   = (state_q == S_HALT);
    error    = (state_q == S_ERROR);
    err_code = err_q;
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed, table-driven bench for instr_sequencer: one record per clock cycle
// holding the inputs for that cycle and the outputs expected during it.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [15:0] halt_addr;
  logic [15:0] pc_value;
  logic        fetch_done;
  logic [3:0]  opcode;
  logic [5:0]  exec_done;
  logic        start_fetch;
  logic [5:0]  start_exec;
  logic [2:0]  owner;
  logic        busy;
  logic        halted;
  logic        error;
  logic [1:0]  err_code;

  instr_sequencer #(.TIMEOUT(8), .ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .run(run), .halt_addr(halt_addr), .pc_value(pc_value),
    .fetch_done(fetch_done), .opcode(opcode), .exec_done(exec_done),
    .start_fetch(start_fetch), .start_exec(start_exec), .owner(owner), .busy(busy),
    .halted(halted), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        run;
    logic [15:0] pc;
    logic        fd;
    logic [3:0]  op;
    logic [5:0]  ed;
    logic [14:0] exp;
    logic [14:0] mask;
    int          scn;
  } vec_t;

  vec_t tbl[$];
  int   cur_scn;
  int   n_vec;
  int   n_bad;

  logic [14:0] O_IDLE, O_FS, O_FW, O_HALT;

  // {start_fetch, start_exec[5:0], owner[2:0], busy, halted, error, err_code[1:0]}
  function automatic logic [14:0] pk(input logic sf, input logic [5:0] se, input logic [2:0] ow,
                                     input logic b, input logic h, input logic e,
                                     input logic [1:0] ec);
    return {sf, se, ow, b, h, e, ec};
  endfunction

  function automatic logic [14:0] o_disp(input int s);
    return pk(1'b0, 6'(1 << s), 3'(2 + s), 1'b1, 1'b0, 1'b0, 2'd0);
  endfunction

  function automatic logic [14:0] o_ew(input int s);
    return pk(1'b0, 6'd0, 3'(2 + s), 1'b1, 1'b0, 1'b0, 2'd0);
  endfunction

  function automatic logic [14:0] o_err(input logic [1:0] c);
    return pk(1'b0, 6'd0, 3'd0, 1'b0, 1'b0, 1'b1, c);
  endfunction

  function automatic vec_t mk(input logic rst, input logic rn, input logic [15:0] pc,
                              input logic fd, input logic [3:0] op, input logic [5:0] ed,
                              input logic [14:0] exp, input logic [14:0] mask = 15'h7FFF);
    vec_t v;
    v.rst = rst; v.run = rn; v.pc = pc; v.fd = fd; v.op = op; v.ed = ed;
    v.exp = exp; v.mask = mask; v.scn = cur_scn;
    return v;
  endfunction

  task automatic add(input logic rst, input logic rn, input logic [15:0] pc,
                     input logic fd, input logic [3:0] op, input logic [5:0] ed,
                     input logic [14:0] exp, input logic [14:0] mask = 15'h7FFF);
    tbl.push_back(mk(rst, rn, pc, fd, op, ed, exp, mask));
  endtask

  task automatic check(input logic [14:0] exp, input logic [14:0] mask, input string name);
    logic [14:0] act;
    act = {start_fetch, start_exec, owner, busy, halted, error, err_code};
    n_vec++;
    if ((act & mask) !== (exp & mask)) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (mask %h)", name, act, exp, mask);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    if (v.rst) begin
      reset = 1'b1;
      #1;
      reset = 1'b0;
    end
    run        = v.run;
    pc_value   = v.pc;
    halt_addr  = 16'd7;
    fetch_done = v.fd;
    opcode     = v.op;
    exec_done  = v.ed;
    #1;
    check(v.exp, v.mask, name);
  endtask

  initial begin
    n_vec = 0; n_bad = 0; cur_scn = 0;
    O_IDLE = '0;
    O_FS   = pk(1'b1, 6'd0, 3'd1, 1'b1, 1'b0, 1'b0, 2'd0);
    O_FW   = pk(1'b0, 6'd0, 3'd1, 1'b1, 1'b0, 1'b0, 2'd0);
    O_HALT = pk(1'b0, 6'd0, 3'd0, 1'b0, 1'b1, 1'b0, 2'd0);

    // scenario 1: ALU loop pc 1..7, stray done pulses sprinkled in, halts on pc==7
    cur_scn = 1;
    add(1, 1, 0, 0, 0, 0, O_IDLE);
    for (int i = 0; i < 7; i++) begin
      add(0, 1, 16'(i + 1), (i == 4), 4'h3, (i == 2) ? 6'b000100 : 6'b0, O_FS);
      add(0, 1, 16'(i + 1), 1, 4'h3, 0, O_FW);
      add(0, 1, 16'(i + 1), 0, 4'h3, 0, o_disp(2));
      add(0, 1, 16'(i + 1), (i == 3), 4'h3, 6'b000100, o_ew(2));
    end
    add(0, 1, 7, 0, 0, 0, O_HALT);
    add(0, 0, 7, 0, 0, 0, O_HALT);
    add(0, 0, 7, 0, 0, 0, O_IDLE);

    // scenario 2: illegal opcode, no start pulse, error sticky across run toggles
    cur_scn = 2;
    add(1, 1, 1, 0, 0, 0, O_IDLE);
    add(0, 1, 1, 0, 0, 0, O_FS);
    add(0, 1, 1, 1, 4'hD, 0, O_FW);
    add(0, 1, 1, 0, 0, 0, pk(1'b0, 6'd0, 3'd0, 1'b1, 1'b0, 1'b0, 2'd0), 15'h7F1F);
    add(0, 1, 1, 0, 0, 0, o_err(1));
    add(0, 0, 1, 0, 0, 0, o_err(1));
    add(0, 1, 1, 0, 0, 6'b000001, o_err(1));

    // scenario 3: load waiting, store's done arrives instead
    cur_scn = 3;
    add(1, 1, 1, 0, 0, 0, O_IDLE);
    add(0, 1, 1, 0, 0, 0, O_FS);
    add(0, 1, 1, 1, 4'hA, 0, O_FW);
    add(0, 1, 1, 0, 0, 0, o_disp(4));
    add(0, 1, 1, 0, 0, 6'b100000, o_ew(4));
    add(0, 1, 1, 0, 0, 0, o_err(2));
    add(0, 0, 1, 0, 0, 0, o_err(2));

    // scenario 4: correct load done completes; store done together with another bit errors
    cur_scn = 4;
    add(1, 1, 1, 0, 0, 0, O_IDLE);
    add(0, 1, 1, 0, 0, 0, O_FS);
    add(0, 1, 1, 1, 4'hA, 0, O_FW);
    add(0, 1, 1, 0, 0, 0, o_disp(4));
    add(0, 1, 1, 0, 0, 6'b010000, o_ew(4));
    add(0, 1, 2, 0, 0, 0, O_FS);
    add(0, 1, 2, 1, 4'hB, 0, O_FW);
    add(0, 1, 2, 0, 0, 0, o_disp(5));
    add(0, 1, 2, 0, 0, 6'b100001, o_ew(5));
    add(0, 1, 2, 0, 0, 0, o_err(2));

    // scenario 5: fetch never completes, error after 7 cycles in FETCH_WAIT
    cur_scn = 5;
    add(1, 1, 1, 0, 0, 0, O_IDLE);
    add(0, 1, 1, 0, 0, 0, O_FS);
    for (int i = 0; i < 7; i++) add(0, 1, 1, 0, 0, 0, O_FW);
    add(0, 1, 1, 0, 0, 0, o_err(3));
    add(0, 1, 1, 1, 0, 0, o_err(3));

    // scenario 6: fetch done on the last permitted cycle beats the timeout
    cur_scn = 6;
    add(1, 1, 1, 0, 0, 0, O_IDLE);
    add(0, 1, 1, 0, 0, 0, O_FS);
    for (int i = 0; i < 6; i++) add(0, 1, 1, 0, 0, 0, O_FW);
    add(0, 1, 1, 1, 4'h0, 0, O_FW);
    add(0, 1, 1, 0, 0, 0, o_disp(0));
    add(0, 1, 1, 0, 0, 6'b000001, o_ew(0));
    add(0, 1, 2, 0, 0, 0, O_FS);

    // scenario 7: run dropped during movi execution, completes then idles
    cur_scn = 7;
    add(1, 1, 1, 0, 0, 0, O_IDLE);
    add(0, 1, 1, 0, 0, 0, O_FS);
    add(0, 1, 1, 1, 4'h1, 0, O_FW);
    add(0, 1, 1, 0, 0, 0, o_disp(1));
    add(0, 0, 1, 0, 0, 0, o_ew(1));
    add(0, 0, 1, 0, 0, 6'b000010, o_ew(1));
    add(0, 0, 1, 0, 0, 0, O_IDLE);
    add(0, 0, 1, 0, 0, 0, O_IDLE);
    add(0, 1, 1, 0, 0, 0, O_IDLE);
    add(0, 1, 1, 0, 0, 0, O_FS);

    // scenario 8: run with pc already at halt_addr goes straight to HALT
    cur_scn = 8;
    add(1, 1, 7, 0, 0, 0, O_IDLE);
    add(0, 0, 7, 0, 0, 0, O_HALT);
    add(0, 0, 7, 0, 0, 0, O_IDLE);

    // hand-written: reset state, then async reset mid-EXEC_WAIT
    reset = 1'b1; run = 1'b0; halt_addr = 16'd7; pc_value = '0;
    fetch_done = 1'b0; opcode = '0; exec_done = '0;
    #1;
    check(O_IDLE, 15'h7FFF, "reset_state");
    @(negedge clk);
    reset = 1'b0;
    cur_scn = 0;
    apply(mk(0, 1, 1, 0, 0, 0, O_IDLE), "pre_rst_idle");
    apply(mk(0, 1, 1, 0, 0, 0, O_FS), "pre_rst_fs");
    apply(mk(0, 1, 1, 1, 4'h4, 0, O_FW), "pre_rst_fw");
    apply(mk(0, 1, 1, 0, 0, 0, o_disp(2)), "pre_rst_disp");
    apply(mk(0, 1, 1, 0, 0, 0, o_ew(2)), "pre_rst_ew");
    #2;
    reset = 1'b1;
    #1;
    check(O_IDLE, 15'h7FFF, "async_reset_outputs");
    @(negedge clk);
    reset = 1'b0;
    run   = 1'b0;
    #1;
    check(O_IDLE, 15'h7FFF, "post_reset_idle");
    apply(mk(0, 0, 1, 0, 0, 6'b000100, O_IDLE), "post_reset_idle2");

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], $sformatf("scn%0d_vec%0d", tbl[i].scn, i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
